mac_cfg_master: RTL and testbench

Configuration initiator for the MAC accelerator's peripheral port. It drives the master side of the HWPE control peripheral protocol (req/gnt request phase, r_valid response phase) from a simple command stream. The block lets a testbench host, a DMA-style sequencer or a small controller do four things without a core:
- program job registers,
- trigger the job,
- poll status or debug registers until a masked match,
- wait for the accelerator's completion event.

It sits between a command source and the accelerator's `periph` slave port.

---
 rtl/mac_cfg_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_mac_cfg_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_cfg_master.sv
// mac_cfg_master
// Configuration initiator for the MAC accelerator's peripheral port. A simple
// command stream (WRITE, READ, POLL, WAIT_EVT) is turned into master-side
// transactions on the HWPE control peripheral protocol. The protocol has a
// req/gnt request phase and an r_valid response phase. Each accepted command
// produces exactly one response on the rsp_* stream.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   clear_i                 synchronous soft clear
//   cmd_valid_i/cmd_ready_o command handshake
//   cmd_op_i                00 WRITE, 01 READ, 10 POLL, 11 WAIT_EVT
//   cmd_addr_i/data_i/mask_i/be_i   command payload
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o/rsp_err_o    response payload
//   req_o/gnt_i, add_o, wen_o, be_o, data_o, id_o   periph request phase
//   r_valid_i, r_data_i, r_id_i                     periph response phase
//   evt_i                   accelerator completion event
//   timeout_i               POLL/WAIT_EVT cycle limit, 0 = unlimited
//   busy_o                  high whenever the FSM is not idle
module mac_cfg_master #(
    parameter int unsigned ID_WIDTH  = 10,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [31:0]          cmd_data_i,
    input  logic [31:0]          cmd_mask_i,
    input  logic [3:0]           cmd_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 req_o,
    output logic [31:0]          add_o,
    output logic                 wen_o,
    output logic [3:0]           be_o,
    output logic [31:0]          data_o,
    output logic [ID_WIDTH-1:0]  id_o,
    input  logic                 gnt_i,
    input  logic [31:0]          r_data_i,
    input  logic                 r_valid_i,
    input  logic [ID_WIDTH-1:0]  r_id_i,
    input  logic                 evt_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_GAP,
        S_EVT,
        S_RSP
    } state_e;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_POLL     = 2'b10;
    localparam logic [1:0] OP_WAIT_EVT = 2'b11;

    localparam int unsigned      GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    state_e               state_q;
    logic [1:0]           op_q;
    logic [31:0]          data_q;
    logic [31:0]          mask_q;
    logic [ID_WIDTH-1:0]  id_cnt_q;
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic                 evt_pending_q;
    logic                 clear_pending_q;

    logic accept;
    logic hard_clear;
    logic limit_reached;
    logic poll_match;
    logic tmo_active;
    logic evt_clear;

    // A clear in REQ cannot abandon the request already on the bus, so it is
    // deferred until the grant. In every other state it takes effect at once.
    assign accept        = cmd_valid_i & cmd_ready_o;
    assign hard_clear    = clear_i & (state_q != S_REQ);
    assign limit_reached = (timeout_i != '0) && (tmo_cnt_q >= timeout_i);
    assign poll_match    = ((r_data_i & mask_q) == (data_q & mask_q));
    assign tmo_active    = ((op_q == OP_POLL) || (op_q == OP_WAIT_EVT)) &&
                           (state_q inside {S_REQ, S_WAIT_RSP, S_GAP, S_EVT});
    assign evt_clear     = ((state_q == S_EVT) && evt_pending_q) || hard_clear;
    assign busy_o        = (state_q != S_IDLE);

    // Event latch: remembers an evt_i pulse that arrives before the WAIT_EVT
    // command that needs it. An event in the same cycle as the consume is
    // absorbed by that consume; any later event sets the latch again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_pending_q <= 1'b0;
        end else if (evt_clear) begin
            evt_pending_q <= 1'b0;
        end else if (evt_i) begin
            evt_pending_q <= 1'b1;
        end
    end

    // Timeout counter: restarts on every accepted command and saturates
    // instead of wrapping, so a long wait can never appear to be short.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (accept || hard_clear) begin
            tmo_cnt_q <= '0;
        end else if (tmo_active && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Main FSM: all periph and response outputs are registered here and are
    // held between updates, which gives the protocol its stability guarantees.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            op_q            <= OP_WRITE;
            data_q          <= '0;
            mask_q          <= '0;
            id_cnt_q        <= '0;
            gap_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            cmd_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_err_o       <= 1'b0;
            req_o           <= 1'b0;
            add_o           <= '0;
            wen_o           <= 1'b0;
            be_o            <= '0;
            data_o          <= '0;
            id_o            <= '0;
        end else if (hard_clear && (state_q != S_IDLE)) begin
            state_q         <= S_IDLE;
            cmd_ready_o     <= 1'b1;
            req_o           <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_err_o       <= 1'b0;
            id_cnt_q        <= '0;
            clear_pending_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (clear_i) begin
                        id_cnt_q   <= '0;
                        rsp_data_o <= '0;
                        rsp_err_o  <= 1'b0;
                    end
                    if (accept) begin
                        cmd_ready_o <= 1'b0;
                        op_q        <= cmd_op_i;
                        data_q      <= cmd_data_i;
                        mask_q      <= cmd_mask_i;
                        if (cmd_op_i == OP_WAIT_EVT) begin
                            state_q <= S_EVT;
                        end else begin
                            state_q <= S_REQ;
                            req_o   <= 1'b1;
                            add_o   <= cmd_addr_i;
                            wen_o   <= (cmd_op_i != OP_WRITE);
                            be_o    <= (cmd_op_i == OP_WRITE) ? cmd_be_i : 4'hF;
                            data_o  <= (cmd_op_i == OP_WRITE) ? cmd_data_i : 32'h0;
                            id_o    <= clear_i ? '0 : id_cnt_q;
                        end
                    end
                end

                S_REQ: begin
                    if (clear_i) begin
                        clear_pending_q <= 1'b1;
                    end
                    if (gnt_i) begin
                        req_o    <= 1'b0;
                        id_cnt_q <= id_cnt_q + 1'b1;
                        if (clear_pending_q || clear_i) begin
                            state_q         <= S_IDLE;
                            cmd_ready_o     <= 1'b1;
                            clear_pending_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_RSP;
                        end
                    end
                end

                // Writes also wait for r_valid; a mismatched id ends any op
                // with an error regardless of the returned data.
                S_WAIT_RSP: begin
                    if (r_valid_i) begin
                        rsp_data_o <= (op_q == OP_WRITE) ? 32'h0 : r_data_i;
                        rsp_err_o  <= 1'b0;
                        if (r_id_i != id_o) begin
                            state_q     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else if ((op_q != OP_POLL) || poll_match) begin
                            state_q     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                        end else if (limit_reached) begin
                            state_q     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_REQ;
                        req_o   <= 1'b1;
                        id_o    <= id_cnt_q;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                S_EVT: begin
                    if (evt_pending_q || limit_reached) begin
                        state_q     <= S_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= !evt_pending_q;
                    end
                end

                S_RSP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cfg_master.sv
// tb_mac_cfg_master
// Directed bench for mac_cfg_master. A behavioural periph slave with a
// programmable grant delay answers each granted request one cycle later.
// Read data comes from a queue. Each scenario task drives commands and
// compares DUT outputs against hand-computed values. Inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_mac_cfg_master;

    localparam int ID_WIDTH  = 10;
    localparam int TIMEOUT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic                 cmd_valid_i = 1'b0;
    logic                 cmd_ready_o;
    logic [1:0]           cmd_op_i = '0;
    logic [31:0]          cmd_addr_i = '0;
    logic [31:0]          cmd_data_i = '0;
    logic [31:0]          cmd_mask_i = '0;
    logic [3:0]           cmd_be_i = '0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i = 1'b1;
    logic [31:0]          rsp_data_o;
    logic                 rsp_err_o;
    logic                 req_o;
    logic [31:0]          add_o;
    logic                 wen_o;
    logic [3:0]           be_o;
    logic [31:0]          data_o;
    logic [ID_WIDTH-1:0]  id_o;
    logic                 gnt_i = 1'b0;
    logic [31:0]          r_data_i = '0;
    logic                 r_valid_i = 1'b0;
    logic [ID_WIDTH-1:0]  r_id_i = '0;
    logic                 evt_i = 1'b0;
    logic [TIMEOUT_W-1:0] timeout_i = '0;
    logic                 busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          gnt_delay  = 0;
    int          wait_cnt   = 0;
    bit          slv_rsp_en = 1'b1;
    bit          slv_bad_id = 1'b0;
    logic [31:0] rd_data_q[$];
    int          rises[$];

    mac_cfg_master #(
        .ID_WIDTH (ID_WIDTH),
        .POLL_GAP (4),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_data_i (cmd_data_i),
        .cmd_mask_i (cmd_mask_i),
        .cmd_be_i   (cmd_be_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .req_o      (req_o),
        .add_o      (add_o),
        .wen_o      (wen_o),
        .be_o       (be_o),
        .data_o     (data_o),
        .id_o       (id_o),
        .gnt_i      (gnt_i),
        .r_data_i   (r_data_i),
        .r_valid_i  (r_valid_i),
        .r_id_i     (r_id_i),
        .evt_i      (evt_i),
        .timeout_i  (timeout_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Periph slave: grants after gnt_delay request cycles. If gnt_i is high
    // at this falling edge, the handshake completed on the last rising edge,
    // so the response is returned in this cycle.
    always @(negedge clk) begin
        r_valid_i = 1'b0;
        if (gnt_i) begin
            gnt_i    = 1'b0;
            wait_cnt = 0;
            if (slv_rsp_en) begin
                r_valid_i = 1'b1;
                if (rd_data_q.size() > 0) r_data_i = rd_data_q.pop_front();
                else                      r_data_i = 32'h0;
                r_id_i = slv_bad_id ? (id_o ^ 10'h1) : id_o;
            end
        end else if (req_o) begin
            if (wait_cnt >= gnt_delay) gnt_i = 1'b1;
            else                       wait_cnt++;
        end
    end

    // Presents one command and returns the cycle in which it was accepted.
    // The task returns at the falling edge of the following cycle.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] mask,
                            input logic [3:0] be, output int acc);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        cmd_mask_i  = mask;
        cmd_be_i    = be;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!cmd_ready_o) begin
            n_checks++;
            $display("[TB] FAIL cmd_accept: cmd_ready_o=%b after 50 cycles, required 1", cmd_ready_o);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    // Waits a bounded number of cycles for rsp_valid_o. It records every
    // rising cycle of req_o in the rises queue and lets the response
    // handshake complete before returning.
    task automatic wait_rsp(input int budget, output int rcyc,
                            output logic [31:0] d, output logic e);
        bit seen = 1'b0;
        bit prev = 1'b0;
        rcyc = -1;
        d    = 'x;
        e    = 1'bx;
        for (int i = 0; i < budget; i++) begin
            if (req_o && !prev) rises.push_back(cyc);
            prev = req_o;
            if (rsp_valid_o) begin
                seen = 1'b1;
                rcyc = cyc;
                d    = rsp_data_o;
                e    = rsp_err_o;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            $display("[TB] FAIL rsp_wait: no rsp_valid_o within %0d cycles", budget);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", cmd_ready_o); else n_pass++;
        n_checks++; if (req_o !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", req_o); else n_pass++;
        n_checks++; if (rsp_valid_o !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b want 1", cmd_ready_o); else n_pass++;
    endtask

    task automatic test_write();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        gnt_delay = 0;
        send_cmd(2'b00, 32'h20, 32'h5, 32'h0, 4'hF, acc);
        n_checks++; if (req_o !== 1'b1) $display("[TB] FAIL wr_req: got %b want 1", req_o); else n_pass++;
        n_checks++; if (wen_o !== 1'b0) $display("[TB] FAIL wr_wen: got %b want 0", wen_o); else n_pass++;
        n_checks++; if (id_o !== 10'd0) $display("[TB] FAIL wr_id: got %0d want 0", id_o); else n_pass++;
        n_checks++; if (add_o !== 32'h20) $display("[TB] FAIL wr_addr: got %h want 00000020", add_o); else n_pass++;
        n_checks++; if ({be_o, data_o} !== {4'hF, 32'h5}) $display("[TB] FAIL wr_be_data: got %h/%h want f/00000005", be_o, data_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (req_o !== 1'b0) $display("[TB] FAIL wr_req_one_cycle: got %b want 0", req_o); else n_pass++;
        wait_rsp(20, rcyc, d, e);
        n_checks++; if (rcyc !== acc + 3) $display("[TB] FAIL wr_rsp_cycle: got %0d want %0d", rcyc, acc + 3); else n_pass++;
        n_checks++; if ({d, e} !== {32'h0, 1'b0}) $display("[TB] FAIL wr_rsp: got data %h err %b want 0/0", d, e); else n_pass++;
    endtask

    task automatic test_grant_backpressure();
        int acc, rcyc, n;
        logic [31:0] d;
        logic e;
        bit stable = 1'b1;
        gnt_delay = 5;
        rd_data_q.push_back(32'hCAFE);
        send_cmd(2'b01, 32'h1000, 32'h0, 32'h0, 4'h0, acc);
        n = 0;
        while (req_o && n < 20) begin
            if (add_o !== 32'h1000 || wen_o !== 1'b1 || id_o !== 10'd1 || be_o !== 4'hF) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        n_checks++; if (n !== 6) $display("[TB] FAIL bp_req_cycles: got %0d want 6", n); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("[TB] FAIL bp_stable: got unstable req fields, want addr 1000 wen 1 id 1 be f"); else n_pass++;
        wait_rsp(20, rcyc, d, e);
        n_checks++; if (d !== 32'hCAFE) $display("[TB] FAIL bp_rdata: got %h want 0000cafe", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("[TB] FAIL bp_err: got %b want 0", e); else n_pass++;
        n_checks++; if (rcyc !== acc + 8) $display("[TB] FAIL bp_rsp_cycle: got %0d want %0d", rcyc, acc + 8); else n_pass++;
        gnt_delay = 0;
    endtask

    task automatic test_poll();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        rd_data_q.push_back(32'h0);
        rd_data_q.push_back(32'h0);
        rd_data_q.push_back(32'h1);
        rises.delete();
        send_cmd(2'b10, 32'h8, 32'h1, 32'h1, 4'h0, acc);
        n_checks++; if (id_o !== 10'd2) $display("[TB] FAIL poll_first_id: got %0d want 2", id_o); else n_pass++;
        wait_rsp(100, rcyc, d, e);
        n_checks++; if (rises.size() !== 3) $display("[TB] FAIL poll_req_count: got %0d want 3", rises.size()); else n_pass++;
        if (rises.size() == 3) begin
            n_checks++; if (rises[1] - rises[0] !== 6) $display("[TB] FAIL poll_gap1: got %0d want 6", rises[1] - rises[0]); else n_pass++;
            n_checks++; if (rises[2] - rises[1] !== 6) $display("[TB] FAIL poll_gap2: got %0d want 6", rises[2] - rises[1]); else n_pass++;
        end
        n_checks++; if ({d, e} !== {32'h1, 1'b0}) $display("[TB] FAIL poll_rsp: got data %h err %b want 1/0", d, e); else n_pass++;
        n_checks++; if (rcyc !== acc + 15) $display("[TB] FAIL poll_rsp_cycle: got %0d want %0d", rcyc, acc + 15); else n_pass++;
    endtask

    task automatic test_poll_timeout();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        timeout_i = 16'd10;
        rises.delete();
        send_cmd(2'b10, 32'hC, 32'h1, 32'h1, 4'h0, acc);
        wait_rsp(100, rcyc, d, e);
        n_checks++; if (e !== 1'b1) $display("[TB] FAIL pto_err: got %b want 1", e); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("[TB] FAIL pto_data: got %h want 0", d); else n_pass++;
        n_checks++; if (rises.size() !== 3) $display("[TB] FAIL pto_req_count: got %0d want 3", rises.size()); else n_pass++;
        n_checks++; if (rcyc !== acc + 15) $display("[TB] FAIL pto_rsp_cycle: got %0d want %0d", rcyc, acc + 15); else n_pass++;
        n_checks++; if (req_o !== 1'b0) $display("[TB] FAIL pto_req_left: got %b want 0", req_o); else n_pass++;
        timeout_i = '0;
    endtask

    task automatic test_event();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        send_cmd(2'b00, 32'h24, 32'h0, 32'h0, 4'hF, acc);
        evt_i = 1'b1;
        @(negedge clk);
        evt_i = 1'b0;
        wait_rsp(20, rcyc, d, e);
        send_cmd(2'b11, 32'h0, 32'h0, 32'h0, 4'h0, acc);
        n_checks++; if (busy_o !== 1'b1) $display("[TB] FAIL evt_busy: got %b want 1", busy_o); else n_pass++;
        wait_rsp(20, rcyc, d, e);
        n_checks++; if (rcyc !== acc + 2) $display("[TB] FAIL evt_early_cycle: got %0d want %0d", rcyc, acc + 2); else n_pass++;
        n_checks++; if ({d, e} !== {32'h0, 1'b0}) $display("[TB] FAIL evt_early_rsp: got data %h err %b want 0/0", d, e); else n_pass++;
        timeout_i = 16'd8;
        send_cmd(2'b11, 32'h0, 32'h0, 32'h0, 4'h0, acc);
        wait_rsp(40, rcyc, d, e);
        n_checks++; if (e !== 1'b1) $display("[TB] FAIL evt_timeout_err: got %b want 1", e); else n_pass++;
        n_checks++; if (rcyc !== acc + 10) $display("[TB] FAIL evt_timeout_cycle: got %0d want %0d", rcyc, acc + 10); else n_pass++;
        timeout_i = '0;
    endtask

    task automatic test_bad_id();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        slv_bad_id = 1'b1;
        rd_data_q.push_back(32'h55);
        send_cmd(2'b01, 32'h44, 32'h0, 32'h0, 4'h0, acc);
        wait_rsp(20, rcyc, d, e);
        n_checks++; if (e !== 1'b1) $display("[TB] FAIL badid_err: got %b want 1", e); else n_pass++;
        slv_bad_id = 1'b0;
    endtask

    task automatic test_clear();
        int acc, rcyc, n;
        logic [31:0] d;
        logic e;
        bit stray_rsp = 1'b0;
        gnt_delay = 3;
        send_cmd(2'b01, 32'h40, 32'h0, 32'h0, 4'h0, acc);
        clear_i = 1'b1;
        n = 0;
        while (req_o && n < 20) begin
            n++;
            @(negedge clk);
            clear_i = 1'b0;
        end
        n_checks++; if (n !== 4) $display("[TB] FAIL clr_req_cycles: got %0d want 4", n); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL clr_idle: got busy %b want 0", busy_o); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid_o) stray_rsp = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (stray_rsp !== 1'b0) $display("[TB] FAIL clr_no_rsp: got a response, want none"); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("[TB] FAIL clr_ready: got %b want 1", cmd_ready_o); else n_pass++;
        gnt_delay = 0;
        rd_data_q.push_back(32'h1234);
        send_cmd(2'b01, 32'h48, 32'h0, 32'h0, 4'h0, acc);
        wait_rsp(20, rcyc, d, e);
        n_checks++; if ({d, e} !== {32'h1234, 1'b0}) $display("[TB] FAIL clr_next_rsp: got data %h err %b want 1234/0", d, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc, rcyc;
        logic [31:0] d;
        logic e;
        slv_rsp_en = 1'b0;
        send_cmd(2'b01, 32'h1000, 32'h0, 32'h0, 4'h0, acc);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", busy_o); else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({req_o, add_o, wen_o, be_o, data_o, id_o, rsp_valid_o, rsp_data_o, rsp_err_o, cmd_ready_o, busy_o} !== '0)
            $display("[TB] FAIL mid_reset_outputs: got req %b add %h wen %b be %h data %h id %0d rsp %b/%h/%b ready %b busy %b want all 0",
                     req_o, add_o, wen_o, be_o, data_o, id_o, rsp_valid_o, rsp_data_o, rsp_err_o, cmd_ready_o, busy_o);
        else n_pass++;
        slv_rsp_en = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) $display("[TB] FAIL mid_ready_after: got %b want 1", cmd_ready_o); else n_pass++;
        send_cmd(2'b00, 32'h28, 32'h9, 32'h0, 4'h3, acc);
        n_checks++; if ({id_o, be_o} !== {10'd0, 4'h3}) $display("[TB] FAIL mid_id_be: got id %0d be %h want 0/3", id_o, be_o); else n_pass++;
        wait_rsp(20, rcyc, d, e);
        n_checks++; if (rcyc !== acc + 3) $display("[TB] FAIL mid_wr_cycle: got %0d want %0d", rcyc, acc + 3); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_grant_backpressure();
        test_poll();
        test_poll_timeout();
        test_event();
        test_bad_id();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
